// File: rtl/dpram_be_sc.sv
// ============================================================================
//  Module   : dpram_be_sc
//  Purpose  : Single-clock true dual-port RAM with per-byte write enables,
//             selectable read-during-write policy, optional output register,
//             deterministic same-address collision resolution (port A wins
//             per byte), a sequenced clear engine and read-valid strobes.
//  Ports    : clock / reset_n     - rising-edge clock, async active-low reset
//             clear_req / busy    - start a clear sweep / sweep in progress
//             enable_x, wren_x    - access strobe / write select (x = a, b)
//             be_x, address_x     - byte enables / word address
//             data_x, q_x         - write data / read data
//             rd_valid_x          - q_x carries data of an accepted access
//             collision_cnt/pulse - only with DPRAM_COLLISION_STAT_EN defined
//  Options  : `define DPRAM_COLLISION_STAT_EN adds the collision statistics.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_be_sc #(
    parameter int                 ADDR_W         = 8,
    parameter int                 BYTES          = 1,
    parameter int                 RDW_MODE       = 0,
    parameter int                 OUT_REG        = 0,
    parameter int                 CLEAR_ON_RESET = 1,
    parameter logic [8*BYTES-1:0] CLEAR_VALUE    = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear_req,
    output logic                busy,
    input  logic                enable_a,
    input  logic                wren_a,
    input  logic [BYTES-1:0]    be_a,
    input  logic [ADDR_W-1:0]   address_a,
    input  logic [8*BYTES-1:0]  data_a,
    output logic [8*BYTES-1:0]  q_a,
    output logic                rd_valid_a,
    input  logic                enable_b,
    input  logic                wren_b,
    input  logic [BYTES-1:0]    be_b,
    input  logic [ADDR_W-1:0]   address_b,
    input  logic [8*BYTES-1:0]  data_b,
    output logic [8*BYTES-1:0]  q_b,
`ifdef DPRAM_COLLISION_STAT_EN
    output logic [15:0]         collision_cnt,
    output logic                collision_pulse,
`endif
    output logic                rd_valid_b
);

    localparam int DW    = 8 * BYTES;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};

    // ------------------------------------------------------------------------
    // Clear engine: state register / next-state / outputs
    // ------------------------------------------------------------------------
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                // Counter parks at the last address; a new sweep reloads it.
                if (cnt_q == c_last_addr) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_CLEAR);
    end

    // ------------------------------------------------------------------------
    // Access decode and collision resolution
    // ------------------------------------------------------------------------
    logic [DW-1:0]    mem_q [DEPTH];
    logic             w_acc_a, w_acc_b, w_same;
    logic [BYTES-1:0] w_wr_a, w_wr_b;
    logic [DW-1:0]    w_old_a, w_old_b, w_new_a, w_new_b, w_rd_a, w_rd_b;

    assign w_acc_a = enable_a & ~busy;
    assign w_acc_b = enable_b & ~busy;
    assign w_same  = (address_a == address_b);
    assign w_wr_a  = {BYTES{w_acc_a & wren_a}} & be_a;
    // Port B loses any byte that port A also writes at the same address.
    assign w_wr_b  = {BYTES{w_acc_b & wren_b}} & be_b & ~({BYTES{w_same}} & w_wr_a);

    assign w_old_a = mem_q[address_a];
    assign w_old_b = mem_q[address_b];

    // Final post-write word seen at each port's address, including bytes
    // written by the other port in the same cycle.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
        assign w_new_a[8*gi +: 8] = w_wr_a[gi]            ? data_a[8*gi +: 8] :
                                    (w_same & w_wr_b[gi]) ? data_b[8*gi +: 8] :
                                                            w_old_a[8*gi +: 8];
        assign w_new_b[8*gi +: 8] = w_wr_b[gi]            ? data_b[8*gi +: 8] :
                                    (w_same & w_wr_a[gi]) ? data_a[8*gi +: 8] :
                                                            w_old_b[8*gi +: 8];
    end

    assign w_rd_a = (RDW_MODE == 0) ? w_new_a : w_old_a;
    assign w_rd_b = (RDW_MODE == 0) ? w_new_b : w_old_b;

    // Array storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (busy) begin
            mem_q[cnt_q] <= CLEAR_VALUE;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                if (w_wr_a[i]) mem_q[address_a][8*i +: 8] <= data_a[8*i +: 8];
                if (w_wr_b[i]) mem_q[address_b][8*i +: 8] <= data_b[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline: stage 1 always present, stage 2 optional
    // ------------------------------------------------------------------------
    logic [DW-1:0] s1_q_a_q, s1_q_b_q;
    logic          s1_v_a_q, s1_v_b_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q_a_q <= '0;
            s1_q_b_q <= '0;
            s1_v_a_q <= 1'b0;
            s1_v_b_q <= 1'b0;
        end else begin
            s1_v_a_q <= w_acc_a;
            s1_v_b_q <= w_acc_b;
            if (w_acc_a) s1_q_a_q <= w_rd_a;
            if (w_acc_b) s1_q_b_q <= w_rd_b;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DW-1:0] s2_q_a_q, s2_q_b_q;
        logic          s2_v_a_q, s2_v_b_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s2_q_a_q <= '0;
                s2_q_b_q <= '0;
                s2_v_a_q <= 1'b0;
                s2_v_b_q <= 1'b0;
            end else begin
                s2_v_a_q <= s1_v_a_q;
                s2_v_b_q <= s1_v_b_q;
                if (s1_v_a_q) s2_q_a_q <= s1_q_a_q;
                if (s1_v_b_q) s2_q_b_q <= s1_q_b_q;
            end
        end

        assign q_a        = s2_q_a_q;
        assign q_b        = s2_q_b_q;
        assign rd_valid_a = s2_v_a_q;
        assign rd_valid_b = s2_v_b_q;
    end else begin : g_no_out_reg
        assign q_a        = s1_q_a_q;
        assign q_b        = s1_q_b_q;
        assign rd_valid_a = s1_v_a_q;
        assign rd_valid_b = s1_v_b_q;
    end

`ifdef DPRAM_COLLISION_STAT_EN
    // ------------------------------------------------------------------------
    // Same-address collision statistics (saturating)
    // ------------------------------------------------------------------------
    logic        w_coll;
    logic [15:0] coll_cnt_q;
    logic        coll_pulse_q;

    assign w_coll = w_acc_a & w_acc_b & w_same & (wren_a | wren_b);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            coll_cnt_q   <= '0;
            coll_pulse_q <= 1'b0;
        end else begin
            coll_pulse_q <= w_coll;
            if (w_coll && (coll_cnt_q != 16'hFFFF)) begin
                coll_cnt_q <= coll_cnt_q + 16'd1;
            end
        end
    end

    assign collision_cnt   = coll_cnt_q;
    assign collision_pulse = coll_pulse_q;
`endif

endmodule

`default_nettype wire

// File: doc/dpram_be_sc.md
Name: dpram_be_sc

Overview:
- Single-clock, true dual-port block RAM for core video/sprite/work RAMs; the next generation of the team's two-port RAM.
- Adds per-byte write enables, a selectable read-during-write policy, an optional output register and deterministic same-address collision resolution.
- Adds a sequenced clear engine that initialises the array after reset or on request, plus read-valid strobes so consumers can track latency.

Parameters:
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- BYTES, 1, bytes per word; data width DW = 8*BYTES.
- RDW_MODE, 0, read-during-write policy: 0 = new data (write-first), 1 = old data (read-first).
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1, 1 = clear engine runs automatically after reset release.
- CLEAR_VALUE, 0, DW-bit value written to every word by the clear engine.

Ports:
- clock, input, 1, sole clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- clear_req, input, 1, single-cycle request to start a clear sweep.
- busy, output, 1, high while the clear engine owns the array.
- enable_a, input, 1, port A access strobe.
- wren_a, input, 1, port A write when enable_a=1.
- be_a, input, BYTES, port A byte enables (writes only).
- address_a, input, ADDR_W, port A address.
- data_a, input, DW, port A write data.
- q_a, output, DW, port A read data.
- rd_valid_a, output, 1, q_a holds data for an accepted access.
- enable_b, wren_b, be_b, address_b, data_b, q_b, rd_valid_b: port B, same widths and meanings as port A.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - q_a, q_b, rd_valid_a, rd_valid_b = 0; pipeline registers = 0.
  - Clear FSM goes to CLEAR with sweep counter 0 if CLEAR_ON_RESET=1; otherwise to IDLE.
  - busy = CLEAR_ON_RESET.
  - Array contents are not reset.
- Clear FSM, states IDLE and CLEAR:
  - CLEAR: each cycle writes CLEAR_VALUE (all bytes) at counter, then counter+1.
  - CLEAR leaves for IDLE after writing DEPTH-1; busy falls on the next edge. A sweep is exactly DEPTH cycles of busy=1.
  - IDLE: clear_req=1 enters CLEAR with counter 0; busy rises on the next edge.
  - clear_req while in CLEAR is ignored; the sweep does not restart.
  - Reset mid-sweep aborts the sweep; the reset rules above apply.
- Port accesses while busy=1:
  - enable_a/b are ignored: no write, no read, rd_valid stays 0.
  - Accesses in the pipe when busy rises still complete.
- Access (busy=0, enable_x=1):
  - Write: byte i of the word at address_x is updated iff be_x[i]=1; wren_x=1 with be_x=0 writes nothing.
  - Every accepted access, read or write, returns data.
  - OUT_REG=0: q_x and rd_valid_x=1 are presented on the edge after the access; rd_valid_x=1 for one cycle per access.
  - OUT_REG=1: one extra cycle of latency; back-to-back accesses stream at one per cycle.
  - enable_x=0: q_x holds its last value; rd_valid_x=0 at the matching stage.
- Read-during-write, same port:
  - RDW_MODE=0: q = merged word (new bytes where be set, old elsewhere).
  - RDW_MODE=1: q = old word.
- Cross-port, same address, one port writes and the other reads: same rule as same-port. RDW_MODE=0 forwards the merged word to the reader; RDW_MODE=1 returns the old word.
- Write/write collision, same address:
  - Per byte, port A wins where be_a[i]=1; port B's byte is written where be_b[i]=1 and be_a[i]=0.
  - Both ports' read data follow RDW_MODE: merged final word, or old word.
- Different addresses: fully independent; both ports may write in the same cycle.
- Address arithmetic: sweep counter is ADDR_W bits and stops at DEPTH-1; it never wraps into a second pass.

Optional Feature:
- Macro: DPRAM_COLLISION_STAT_EN.
- Defined:
  - Adds output collision_cnt [15:0], reset 0.
  - Increments by 1 on every cycle with busy=0, enable_a=enable_b=1, equal addresses, and at least one port writing.
  - Saturates at 16'hFFFF.
  - Adds output collision_pulse, registered, high for one cycle per counted event.
- Not defined: neither port exists; no collision logic is synthesised; array behaviour is identical.

Test Plan:
- Reset then release, ADDR_W=4, CLEAR_VALUE=8'hA5: busy=1 for exactly 16 cycles; afterwards a read of address 7 gives q=8'hA5 and rd_valid=1 one cycle later (OUT_REG=0), two cycles later (OUT_REG=1).
- BYTES=2, word 3 = 16'h1234; port A writes 16'hABCD with be=2'b01, then reads: q=16'h12CD; RDW_MODE=0 write cycle returns 16'h12CD, RDW_MODE=1 returns 16'h1234.
- Same cycle, A writes 16'hAAAA be=2'b10 and B writes 16'hBBBB be=2'b11 to address 5: word 5 = 16'hAABB; with the macro defined, collision_cnt=1 and collision_pulse for one cycle.
- Port A writes 8'h3C to address 9 while port B reads address 9 (old word 8'h00): q_b=8'h3C for RDW_MODE=0, 8'h00 for RDW_MODE=1.
- clear_req in IDLE with accesses issued during the sweep: the accesses cause no writes and rd_valid stays 0; all words read CLEAR_VALUE afterwards. A second clear_req mid-sweep does not lengthen busy.
- reset_n low at sweep counter 6 of 16, then released: busy=1 for the full 16 cycles and all words are cleared.
